// File: rtl/matrix_keypad.sv
// matrix_keypad -- scanned key matrix with per-key debounce and an event queue.
//
// Drives one column low at a time, samples the (synchronized, pulled-up) rows
// at the end of each column's settle period, then walks the sampled rows one
// per cycle through a per-key debounce counter. Every debounced state change
// produces a {key, pressed} event that is queued for a ready/valid consumer.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   column_pins  active-low column drive, exactly one bit low
//   row_pins     row sense, 0 = pressed on the driven column
//   keys         debounced key state, bit row*COLS+col, 1 = pressed
//   ev_valid     event queue head valid
//   ev_ready     consumer accepts the head event
//   ev_key       key index of the head event
//   ev_pressed   1 = press, 0 = release, for the head event
//   overflow     sticky: at least one event was dropped
module matrix_keypad #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int CLK_FREQ   = 16_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int NKEYS     = ROWS * COLS,
  localparam int KW        = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [COLS-1:0]  column_pins,
  input  logic [ROWS-1:0]  row_pins,
  output logic [NKEYS-1:0] keys,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [KW-1:0]    ev_key,
  output logic             ev_pressed,
  output logic             overflow
);

  localparam int SETTLE = CLK_FREQ / SCAN_HZ;
  localparam int DIV_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef enum logic {
    W_IDLE,
    W_WALK
  } walk_state_t;

  logic [ROWS-1:0]  row_meta;
  logic [ROWS-1:0]  row_sync;
  logic [DIV_W-1:0] div;
  logic [COL_W-1:0] col;
  logic [ROWS-1:0]  sample;
  logic [COL_W-1:0] walk_col;
  logic [ROW_W-1:0] walk_row;
  walk_state_t      walk_state;
  logic [3:0]       cnt [NKEYS];

  logic [KW:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   fill;

  logic             scan_tick;
  logic             walking;
  logic [KW-1:0]    walk_key;
  logic             walk_bit;
  logic [3:0]       cnt_inc;
  logic             disagree;
  logic             ev_gen;
  logic             full;
  logic             pop;
  logic             push;

  assign scan_tick = (div == DIV_W'(SETTLE - 1));
  assign walking   = (walk_state == W_WALK);
  assign walk_key  = KW'(int'(walk_row) * COLS + int'(walk_col));
  assign walk_bit  = sample[walk_row];
  assign cnt_inc   = cnt[walk_key] + 4'd1;
  assign disagree  = (walk_bit != keys[walk_key]);
  assign ev_gen    = walking && disagree && (cnt_inc == 4'(DEBOUNCE));

  assign full      = (fill == (PTR_W + 1)'(FIFO_DEPTH));
  assign ev_valid  = (fill != '0);
  assign pop       = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot, so a full queue still takes the push.
  assign push      = ev_gen && (!full || pop);

  assign ev_key     = fifo_mem[rd_ptr][KW:1];
  assign ev_pressed = fifo_mem[rd_ptr][0];

  always_comb begin
    column_pins      = '1;
    column_pins[col] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta   <= '0;
      row_sync   <= '0;
      div        <= '0;
      col        <= '0;
      sample     <= '0;
      walk_col   <= '0;
      walk_row   <= '0;
      walk_state <= W_IDLE;
      keys       <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      row_meta <= row_pins;
      row_sync <= row_meta;

      // Walk one row of the latched sample per cycle.
      if (walking) begin
        if (!disagree) begin
          cnt[walk_key] <= '0;
        end else if (cnt_inc == 4'(DEBOUNCE)) begin
          cnt[walk_key]  <= '0;
          keys[walk_key] <= walk_bit;
        end else begin
          cnt[walk_key] <= cnt_inc;
        end
        if (walk_row == ROW_W'(ROWS - 1)) begin
          walk_state <= W_IDLE;
        end else begin
          walk_row <= walk_row + 1'b1;
        end
      end

      // The walk (ROWS cycles) always ends before the next tick, so the
      // tick's walker assignments never collide with an active walk.
      if (scan_tick) begin
        div        <= '0;
        col        <= (col == COL_W'(COLS - 1)) ? '0 : col + 1'b1;
        sample     <= ~row_sync;
        walk_col   <= col;
        walk_row   <= '0;
        walk_state <= W_WALK;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !pop) begin
        fill <= fill + 1'b1;
      end else if (pop && !push) begin
        fill <= fill - 1'b1;
      end
      if (ev_gen && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {walk_key, walk_bit};
    end
  end

endmodule

// File: doc/matrix_keypad.md
MATRIX_KEYPAD -- requirements
Module: matrix_keypad

Interface
REQ-001 Parameter ROWS, default 4: number of row inputs.
REQ-002 Parameter COLS, default 4: number of column outputs.
REQ-003 Parameter CLK_FREQ, default 16_000_000: clk frequency in Hz.
REQ-004 Parameter SCAN_HZ, default 1000: column step rate; SETTLE = CLK_FREQ/SCAN_HZ cycles per column, SETTLE >= ROWS+4.
REQ-005 Parameter DEBOUNCE, default 4: consecutive disagreeing samples needed to flip a key, range 1..15.
REQ-006 Parameter FIFO_DEPTH, default 4: event queue entries, power of two, >= 2.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 column_pins  output  COLS  active-low column drive; exactly one bit low at all times.
REQ-010 row_pins  input  ROWS  row sense, externally pulled up; 0 = pressed on the driven column.
REQ-011 keys  output  ROWS*COLS  debounced state, bit index = row*COLS+col, 1 = pressed.
REQ-012 ev_valid  output  1  event queue head valid.
REQ-013 ev_ready  input  1  consumer accepts the head event.
REQ-014 ev_key  output  clog2(ROWS*COLS)  key index of head event.
REQ-015 ev_pressed  output  1  1 = press, 0 = release, for head event.
REQ-016 overflow  output  1  sticky: at least one event dropped.

Function
REQ-017 row_pins SHALL pass through a 2-flop synchronizer before any use.
REQ-018 Divider SHALL count 0..SETTLE-1 and wrap; column index advances 0..COLS-1, wrapping COLS-1 -> 0, on the cycle divider = SETTLE-1.
REQ-019 column_pins SHALL be decoded combinationally from column index: bit[col] = 0, all others 1.
REQ-020 On divider = SETTLE-1, the inverted synchronized rows SHALL be latched as the sample of the current column.
REQ-021 Over the ROWS cycles after the latch, an update walker SHALL process one row per cycle, r = 0..ROWS-1, key k = r*COLS+col of the sampled column.
REQ-022 Per key, 4-bit counter: sample == keys[k] -> counter 0; else counter+1; when counter+1 = DEBOUNCE, keys[k] toggles, counter 0, and one event {k, new state} is generated that cycle.
REQ-023 Event with queue not full SHALL be enqueued; event with queue full and no pop that cycle SHALL be dropped, overflow set to 1; keys still updates.
REQ-024 Pop SHALL occur when ev_valid && ev_ready; a simultaneous push and pop on a full queue SHALL accept the push.
REQ-025 ev_key/ev_pressed SHALL be stable while ev_valid=1 and ev_ready=0; events leave in generation order.
REQ-026 Latency: from the walker cycle generating an event into an empty queue to ev_valid=1 SHALL be 1 cycle.
REQ-027 overflow SHALL clear only on reset.
REQ-028 Press and release of the same key within one debounce window SHALL generate no event.

Reset
REQ-029 reset SHALL set divider 0, column index 0 (column_pins = all ones except bit 0 low), synchronizer 0, counters 0, keys 0, queue empty, ev_valid 0, overflow 0.
REQ-030 reset asserted mid-scan or mid-walk SHALL abandon the walk; no event from that sample is enqueued; first sample after release is of column 0 at divider = SETTLE-1.
REQ-031 ev_key/ev_pressed SHALL be don't-care while ev_valid = 0.

Verification (CLK_FREQ=1000, SCAN_HZ=100 -> SETTLE=10, ROWS=COLS=4, DEBOUNCE=3, FIFO_DEPTH=2)
REQ-032 Idle rows all 1 after reset -> column_pins 1110, 1101, 1011, 0111 each for 10 cycles, repeating every 40; keys = 0, ev_valid = 0.
REQ-033 Hold row 1 low while column 2 driven, ev_ready=1 -> after 3rd column-2 sample, keys[6]=1, single event ev_key=6, ev_pressed=1; release -> after 3 samples keys[6]=0, event {6,0}.
REQ-034 Row 1 low for only 2 consecutive column-2 samples -> no event, keys[6] stays 0.
REQ-035 ev_ready=0, rows 0..3 all low on column 0 -> keys 0,4,8,12 set; events {0,1},{4,1} queued, {8,1},{12,1} dropped, overflow=1; head held stable until ev_ready=1.
REQ-036 reset pulsed one cycle during a walk with events pending -> next cycle all REQ-029 values; no stale event appears.
